// File: rtl/multicrack_if.sv
// Request/result bus of the multi-core ARC4 key cracker, plus the top-level CT memory read port.
interface multicrack_if #(
  parameter int unsigned KEY_W     = 24,
  parameter int unsigned NUM_CORES = 4
);
  localparam int unsigned CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic [7:0]       ct_addr;
  logic [7:0]       ct_rddata;
  logic [CID_W-1:0] core_id;

  modport master (output en, ct_rddata, input rdy, key, key_valid, ct_addr, core_id);
  modport slave  (input en, ct_rddata, output rdy, key, key_valid, ct_addr, core_id);
endinterface

// File: rtl/multicrack.sv
// N-way brute-force ARC4 key search: fill per-core CT copies, race the cores,
// then re-decrypt with the winning key into the internal PT memory.

// ARC4 decryptor: length-prefixed CT in (1-cycle read latency), PT bytes out as write strobes.
module mc_arc4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        abort,
  input  logic [23:0] key,
  output logic        rdy,
  output logic [7:0]  ct_addr,
  input  logic [7:0]  ct_rddata,
  output logic        pt_we_c,
  output logic [7:0]  pt_addr_c,
  output logic [7:0]  pt_data_c
);
  typedef enum logic [2:0] {A_IDLE, A_INIT, A_KSA, A_LEN, A_LENW, A_PRA, A_PRB} a_state_e;
  a_state_e   state;
  logic [7:0] s [256];
  logic [7:0] i, j, len, k;
  logic [1:0] kidx;
  logic [7:0] kbyte, j_ksa, i_nx, j_prg, pad_idx;

  always_comb begin
    kbyte     = (kidx == 2'd0) ? key[23:16] : (kidx == 2'd1) ? key[15:8] : key[7:0];
    j_ksa     = j + s[i] + kbyte;
    i_nx      = i + 8'd1;
    j_prg     = j + s[i_nx];
    pad_idx   = s[i] + s[j];
    pt_we_c   = (state == A_LENW) || (state == A_PRB);
    pt_addr_c = (state == A_LENW) ? 8'd0 : k;
    pt_data_c = (state == A_LENW) ? ct_rddata : (ct_rddata ^ s[pad_idx]);
  end

  // S-box storage: identity fill, then swaps for key schedule and keystream
  always_ff @(posedge clk) begin
    case (state)
      A_INIT: s[i] <= i;
      A_KSA: begin
        s[i]     <= s[j_ksa];
        s[j_ksa] <= s[i];
      end
      A_PRA: begin
        s[i_nx]  <= s[j_prg];
        s[j_prg] <= s[i_nx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= A_IDLE; rdy <= 1'b1; i <= '0; j <= '0; k <= '0;
      len <= '0; kidx <= '0; ct_addr <= '0;
    end else if (abort) begin
      state <= A_IDLE; rdy <= 1'b1;
    end else begin
      case (state)
        A_IDLE: if (en) begin state <= A_INIT; rdy <= 1'b0; i <= '0; end
        A_INIT: begin
          i <= i_nx;
          if (i == 8'hFF) begin state <= A_KSA; j <= '0; kidx <= '0; end
        end
        A_KSA: begin
          i    <= i_nx;
          j    <= j_ksa;
          kidx <= (kidx == 2'd2) ? 2'd0 : 2'(kidx + 2'd1);
          if (i == 8'hFF) begin state <= A_LEN; ct_addr <= '0; end
        end
        A_LEN: state <= A_LENW;
        A_LENW: begin
          len <= ct_rddata; i <= '0; j <= '0; k <= 8'd1;
          if (ct_rddata == 8'd0) begin state <= A_IDLE; rdy <= 1'b1; end
          else begin state <= A_PRA; ct_addr <= 8'd1; end
        end
        A_PRA: begin i <= i_nx; j <= j_prg; state <= A_PRB; end
        A_PRB: begin
          if (k == len) begin state <= A_IDLE; rdy <= 1'b1; end
          else begin k <= k + 8'd1; ct_addr <= k + 8'd1; state <= A_PRA; end
        end
        default: state <= A_IDLE;
      endcase
    end
  end
endmodule

// One crack core: private CT copy, sweeps KEY_START, +STEP, ... up to KEY_LAST.
module mc_crack #(
  parameter int unsigned      KEY_W     = 24,
  parameter int unsigned      STEP      = 4,
  parameter logic [KEY_W-1:0] KEY_LAST  = '1,
  parameter logic [KEY_W-1:0] KEY_START = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             abort,
  input  logic             fill_we,
  input  logic [7:0]       fill_addr,
  input  logic [7:0]       fill_data,
  output logic             rdy,
  output logic             key_valid,
  output logic [KEY_W-1:0] key
);
  typedef enum logic [1:0] {C_IDLE, C_START, C_WAITF, C_WAITR} c_state_e;
  localparam logic [KEY_W:0] LAST_X = {1'b0, KEY_LAST};

  c_state_e       state;
  logic [7:0]     ct_copy [256];
  logic [7:0]     ct_q, eng_addr, pt_addr, pt_data;
  logic           eng_en, eng_rdy, pt_we, bad;
  logic [KEY_W:0] nxt_key;

  assign nxt_key = {1'b0, key} + (KEY_W+1)'(STEP);

  always_ff @(posedge clk) begin
    if (fill_we) ct_copy[fill_addr] <= fill_data;
    ct_q <= ct_copy[eng_addr];
  end

  mc_arc4 u_arc4 (
    .clk(clk), .rst_n(rst_n), .en(eng_en), .abort(abort), .key(24'(key)),
    .rdy(eng_rdy), .ct_addr(eng_addr), .ct_rddata(ct_q),
    .pt_we_c(pt_we), .pt_addr_c(pt_addr), .pt_data_c(pt_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= C_IDLE; rdy <= 1'b1; key_valid <= 1'b0; key <= '0; eng_en <= 1'b0; bad <= 1'b0;
    end else if (abort) begin
      state <= C_IDLE; rdy <= 1'b1; key_valid <= 1'b0; eng_en <= 1'b0;
    end else begin
      case (state)
        C_IDLE: if (en) begin state <= C_START; rdy <= 1'b0; key_valid <= 1'b0; key <= KEY_START; end
        C_START: begin
          if ({1'b0, key} > LAST_X) begin state <= C_IDLE; rdy <= 1'b1; end
          else begin eng_en <= 1'b1; bad <= 1'b0; state <= C_WAITF; end
        end
        C_WAITF: begin
          eng_en <= 1'b0;
          if (!eng_rdy) state <= C_WAITR;
        end
        C_WAITR: begin
          // any non-printable plaintext byte (length byte excluded) rejects the key
          if (pt_we && pt_addr != 8'd0 && (pt_data < 8'h20 || pt_data > 8'h7E)) bad <= 1'b1;
          if (eng_rdy) begin
            if (!bad) begin state <= C_IDLE; rdy <= 1'b1; key_valid <= 1'b1; end
            else if (nxt_key > LAST_X) begin state <= C_IDLE; rdy <= 1'b1; end
            else begin key <= KEY_W'(nxt_key); state <= C_START; end
          end
        end
        default: state <= C_IDLE;
      endcase
    end
  end
endmodule

module multicrack #(
  parameter int unsigned      NUM_CORES = 4,
  parameter int unsigned      KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_LAST  = {KEY_W{1'b1}}
) (
  input logic         clk,
  input logic         rst_n,
  multicrack_if.slave bus
);
  localparam int unsigned CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_LAUNCH, S_SEARCH, S_ABORT, S_VERIFY, S_DONE} state_e;

  state_e               state;
  logic                 rdy_q, key_valid_q, arc_en, arc_rdy, arc_seen;
  logic [KEY_W-1:0]     key_q, win_key;
  logic [CID_W-1:0]     core_id_q, win_id, win_idx_c;
  logic [7:0]           ct_addr_q, len, arc_addr, fill_addr_c, fill_len_c, pt_addr_c, pt_data_c;
  logic [8:0]           fcnt;
  logic                 fill_we_c, fill_last_c, win_any_c, pt_we_c;
  logic [NUM_CORES-1:0] core_en, core_abort, core_rdy, core_valid;
  logic [KEY_W-1:0]     core_key [NUM_CORES];
  logic [7:0]           pt_mem [256];

  assign bus.rdy       = rdy_q;
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.core_id   = core_id_q;
  assign bus.ct_addr   = (state == S_VERIFY) ? arc_addr : ct_addr_q;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    mc_crack #(.KEY_W(KEY_W), .STEP(NUM_CORES), .KEY_LAST(KEY_LAST), .KEY_START(KEY_W'(g))) u_crack (
      .clk(clk), .rst_n(rst_n), .en(core_en[g]), .abort(core_abort[g]),
      .fill_we(fill_we_c), .fill_addr(fill_addr_c), .fill_data(bus.ct_rddata),
      .rdy(core_rdy[g]), .key_valid(core_valid[g]), .key(core_key[g])
    );
  end

  mc_arc4 u_verify (
    .clk(clk), .rst_n(rst_n), .en(arc_en), .abort(1'b0), .key(24'(win_key)),
    .rdy(arc_rdy), .ct_addr(arc_addr), .ct_rddata(bus.ct_rddata),
    .pt_we_c(pt_we_c), .pt_addr_c(pt_addr_c), .pt_data_c(pt_data_c)
  );

  always_ff @(posedge clk) begin
    if (pt_we_c) pt_mem[pt_addr_c] <= pt_data_c;
  end

  // Fill pipeline: data returned in FILL cycle c belongs to address c-1; length comes from byte 0
  always_comb begin
    fill_we_c   = (state == S_FILL) && (fcnt != 9'd0);
    fill_addr_c = 8'(fcnt - 9'd1);
    fill_len_c  = (fcnt == 9'd1) ? bus.ct_rddata : len;
    fill_last_c = fill_we_c && ({1'b0, fill_len_c} == 9'(fcnt - 9'd1));
  end

  // Lowest-index core wins a same-cycle tie
  always_comb begin
    win_any_c = 1'b0;
    win_idx_c = '0;
    for (int n = NUM_CORES - 1; n >= 0; n--) begin
      if (core_rdy[n] && core_valid[n]) begin
        win_any_c = 1'b1;
        win_idx_c = CID_W'(n);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; rdy_q <= 1'b1; key_q <= '1; key_valid_q <= 1'b0; core_id_q <= '0;
      ct_addr_q <= '0; fcnt <= '0; len <= '0; core_en <= '0; core_abort <= '0;
      win_key <= '1; win_id <= '0; arc_en <= 1'b0; arc_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (bus.en) begin
            state <= S_FILL; rdy_q <= 1'b0; key_q <= '1; key_valid_q <= 1'b0;
            core_id_q <= '0; ct_addr_q <= '0; fcnt <= '0;
          end
        end
        S_FILL: begin
          fcnt <= fcnt + 9'd1;
          if (fcnt == 9'd1) len <= bus.ct_rddata;
          if (fcnt == 9'd0 || ct_addr_q < fill_len_c) ct_addr_q <= ct_addr_q + 8'd1;
          if (fill_last_c) begin state <= S_LAUNCH; core_en <= '1; end
        end
        S_LAUNCH: begin
          core_en <= '0;
          if (core_rdy == '0) state <= S_SEARCH;
        end
        S_SEARCH: begin
          if (win_any_c) begin
            win_key    <= core_key[win_idx_c];
            win_id     <= win_idx_c;
            core_abort <= ~(NUM_CORES'(1) << win_idx_c);
            state      <= S_ABORT;
          end else if (core_rdy == '1) begin
            state <= S_DONE; rdy_q <= 1'b1; key_q <= '1; key_valid_q <= 1'b0; core_id_q <= '0;
          end
        end
        S_ABORT: begin
          if (core_rdy == '1) begin
            core_abort <= '0; arc_en <= 1'b1; arc_seen <= 1'b0; state <= S_VERIFY;
          end
        end
        S_VERIFY: begin
          arc_en    <= 1'b0;
          ct_addr_q <= arc_addr;
          if (!arc_rdy) arc_seen <= 1'b1;
          if (arc_seen && arc_rdy) begin
            state <= S_DONE; rdy_q <= 1'b1; key_q <= win_key; key_valid_q <= 1'b1; core_id_q <= win_id;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/multicrack.md
# multicrack

Parametrised brute-force ARC4 key search using `NUM_CORES` crack cores in parallel, each sweeping an interleaved slice of the key space. The block does three things in order:
- Copies the length-prefixed ciphertext from the top-level CT memory into per-core CT copies.
- Runs all cores at once and stops every core as soon as any one of them reports a valid key.
- Re-decrypts with the winning key through an internal arc4 instance into the internal PT memory.

It sits between the top-level CT memory and the board-level result logic. It is the N-way successor of the two-core cracker.

## Interface
Parameters:
- `NUM_CORES`, 4: number of crack instances; power of two, 1..16.
- `KEY_W`, 24: key width in bits.
- `KEY_LAST`, `{KEY_W{1'b1}}`: highest key value searched (inclusive).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  start request; sampled only while `rdy`=1.
- `rdy`  out  1  idle/ready-for-request.
- `key`  out  `KEY_W`  found key; all-ones when none.
- `key_valid`  out  1  `key` is valid.
- `ct_addr`  out  8  top-level CT memory address.
- `ct_rddata`  in  8  top-level CT read data (1-cycle latency).
- `core_id`  out  `$clog2(NUM_CORES)` (min 1)  index of the winning core; 0 when none.

## Operation
- Core `i` is tied to `key_start`=i, `key_step`=`NUM_CORES` and `key_last`=`KEY_LAST`. It has an `abort` input that returns it to idle, with `rdy`=1, within 2 cycles.
- Each core owns a private 256x8 CT copy. During fill, all copies share one address and write strobe.
- Reset values: `rdy`=1, `key`=all-ones, `key_valid`=0, `core_id`=0, `ct_addr`=0. Reset forces state IDLE. It may arrive mid-operation; no partial result survives.
- FSM states:
  - IDLE: `rdy`=1. When `en`=1, the next state is FILL, `rdy`=0, `key`=all-ones, `key_valid`=0.
  - FILL: streams top CT addresses 0..L, where L = byte 0 (message length), and broadcasts each byte into all copies. L is captured from the first returned byte. L=0 copies only byte 0. Addresses above L are not read. Goes to LAUNCH.
  - LAUNCH: pulses `en` of all cores for 1 cycle. Goes to SEARCH once every core has `rdy`=0.
  - SEARCH: waits for completion:
    - Winner: a core with `rdy`=1 and `key_valid`=1. The lowest index wins a same-cycle tie. The winner's key and index are latched, then ABORT.
    - All cores `rdy`=1 and none valid: go to DONE with `key`=all-ones and `key_valid`=0.
  - ABORT: asserts `abort` to all non-winning cores until all report `rdy`=1, then VERIFY.
  - VERIFY: pulses the internal arc4 `en` with the latched key. `ct_addr` is muxed to arc4. Waits for arc4 `rdy` fall then rise, then DONE with `key_valid`=1.
  - DONE: `rdy`=1 and results held, then IDLE.
- Outside FILL and VERIFY, `ct_addr` holds its last value; the top CT memory is never written.
- `en` is ignored while `rdy`=0. `en` held high in DONE/IDLE starts a new search.

## Timing
- FILL is pipelined at one byte per cycle. `ct_addr`=a in cycle t; data arrives in t+1 and is written into all copies at address a in t+1. The whole fill takes L+2 cycles.
- From `en` sample to the first LAUNCH pulse: L+3 cycles.
- Winner detect to core abort: at most 2 cycles. ABORT lasts 2 cycles or less.
- `key`, `key_valid` and `core_id` change only on entry to IDLE→FILL (clearing), on the SEARCH latch (internal only), and on DONE. They are stable while `rdy`=1.
- Worst-case search time is ceil((`KEY_LAST`+1)/`NUM_CORES`) core iterations.

## Test plan
- NUM_CORES=4, CT encrypted with key 24'h000003 → `key`=24'h000003, `key_valid`=1, `core_id`=3, PT memory holds the plaintext.
- NUM_CORES=4, key 24'h000004 → `core_id`=0. Non-winning cores are aborted with `rdy`=1 within 2 cycles of winner detect.
- NUM_CORES=2, `KEY_LAST`=24'h00000F, CT with no valid key → `key`=24'hFFFFFF, `key_valid`=0, `rdy`=1. VERIFY is never entered.
- Message length L=5 → exactly addresses 0..5 are read during FILL. The cycle count from `en` to LAUNCH is 8.
- Reset asserted mid-SEARCH, then a new `en` with a different CT → all outputs return to reset values, and the second search returns the correct key.
- Forced same-cycle completion of cores 1 and 2, both valid → `core_id`=1.
